alu_status_stage: RTL and testbench

Registered stage directly downstream of the 8-bit ALU. Captures the ALU result into a holding register and maintains the 6502 processor status flags (N V D I Z C) from the ALU's carry/overflow outputs and from explicit flag operations (SEC/CLC, SEI/CLI, SED/CLD, CLV, BIT, PLP/RTI). It returns the stored carry to the ALU's `Cin` and drives the packed status byte for PHP/BRK pushes. Optional decimal-mode adjust adds one cycle to ADC/SBC results when D=1.

---
 rtl/alu_status_stage.sv | 215 +++++++++++++++++++++
 tb/tb_alu_status_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_status_stage.sv
// alu_status_stage
// Registered stage behind the 8-bit ALU: holds the ALU result, keeps the
// 6502 status flags N V D I Z C, returns C to the ALU carry-in and builds the
// packed status byte for pushes.
// Optional feature macro: DECIMAL_ADJ_EN
//   defined   -> ADC/SBC with D=1 take a second cycle for BCD adjustment
//   undefined -> 2A03 behaviour: D is stored but never alters results
module alu_status_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    input  logic [7:0] alu_res,
    input  logic       alu_cout,
    input  logic       alu_ovf,
    input  logic [7:0] alu_ain,
    input  logic [7:0] alu_bin,
    input  logic       alu_inv,
    input  logic       alu_sum,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic       set_d,
    input  logic       clr_d,
    input  logic       clr_v,
    input  logic       bit_op,
    input  logic       p_load,
    input  logic [7:0] p_din,
    input  logic       brk_flag,
    output logic [7:0] add_out,
    output logic       out_valid,
    output logic       busy,
    output logic       c_out,
    output logic       d_out,
    output logic [7:0] p_out
);

    logic flag_n;
    logic flag_v;
    logic flag_d;
    logic flag_i;
    logic flag_z;
    logic flag_c;

    logic take_capture;
    logic dec_capture;
    logic bin_capture;
    logic res_zero;
    logic unused_pins;

    assign res_zero = (alu_res == 8'h00);

    // A capture is accepted only when no adjust is pending and the stack
    // load is not overriding the whole status register this cycle.
    assign take_capture = alu_valid & ~busy & ~p_load;
    assign bin_capture  = take_capture & ~dec_capture;

`ifdef DECIMAL_ADJ_EN
    typedef enum logic {
        IDLE,
        ADJ
    } state_t;

    state_t     state;
    logic       adj_hc;
    logic       adj_cout;
    logic       adj_inv;
    logic [7:0] bin_eff;
    logic [7:0] hc_vec;
    logic [7:0] adj_delta;
    logic [7:0] adj_result;
    logic       adj_carry;

    assign busy        = (state == ADJ);
    assign bin_eff     = alu_inv ? ~alu_bin : alu_bin;
    assign hc_vec      = alu_ain ^ bin_eff ^ alu_res;
    assign dec_capture = take_capture & alu_sum & upd_c & flag_d;
    assign unused_pins = ^{p_din[5:4]};

    // BCD correction of the held binary result, using the carries latched
    // in the first cycle; ADC adds 6/0x60, SBC subtracts them.
    always_comb begin
        adj_delta  = 8'h00;
        adj_result = add_out;
        adj_carry  = adj_cout;
        if (!adj_inv) begin
            if (adj_hc || (add_out[3:0] > 4'd9)) begin
                adj_delta[3:0] = 4'h6;
            end
            if (adj_cout || (add_out > 8'h99)) begin
                adj_delta[7:4] = 4'h6;
                adj_carry      = 1'b1;
            end
            adj_result = add_out + adj_delta;
        end else begin
            if (!adj_hc) begin
                adj_delta[3:0] = 4'h6;
            end
            if (!adj_cout) begin
                adj_delta[7:4] = 4'h6;
            end
            adj_result = add_out - adj_delta;
        end
    end
`else
    assign busy        = 1'b0;
    assign dec_capture = 1'b0;
    assign unused_pins = ^{p_din[5:4], alu_ain, alu_bin[5:0], alu_inv, alu_sum};
`endif

    // Result, flags and adjust FSM; later statements carry higher priority
    // (capture, then single-flag ops, then stack load, then adjust carry).
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            flag_d    <= 1'b0;
            flag_i    <= 1'b1;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            add_out   <= 8'h00;
            out_valid <= 1'b0;
`ifdef DECIMAL_ADJ_EN
            state     <= IDLE;
            adj_hc    <= 1'b0;
            adj_cout  <= 1'b0;
            adj_inv   <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;

            if (bin_capture) begin
                add_out   <= alu_res;
                out_valid <= 1'b1;
                if (upd_nz) begin
                    flag_n <= alu_res[7];
                    flag_z <= res_zero;
                end
                if (upd_c) begin
                    flag_c <= alu_cout;
                end
                if (upd_v) begin
                    flag_v <= alu_ovf;
                end
                if (bit_op) begin
                    flag_n <= alu_bin[7];
                    flag_v <= alu_bin[6];
                    flag_z <= res_zero;
                end
            end

`ifdef DECIMAL_ADJ_EN
            case (state)
                IDLE: begin
                    if (dec_capture) begin
                        add_out  <= alu_res;
                        adj_hc   <= hc_vec[4];
                        adj_cout <= alu_cout;
                        adj_inv  <= alu_inv;
                        if (upd_nz) begin
                            flag_n <= alu_res[7];
                            flag_z <= res_zero;
                        end
                        if (upd_v) begin
                            flag_v <= alu_ovf;
                        end
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    add_out   <= adj_result;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase
`endif

            if (set_c || clr_c) begin
                flag_c <= set_c;
            end
            if (set_i || clr_i) begin
                flag_i <= set_i;
            end
            if (set_d || clr_d) begin
                flag_d <= set_d;
            end
            if (clr_v) begin
                flag_v <= 1'b0;
            end

            if (p_load) begin
                flag_n <= p_din[7];
                flag_v <= p_din[6];
                flag_d <= p_din[3];
                flag_i <= p_din[2];
                flag_z <= p_din[1];
                flag_c <= p_din[0];
            end

`ifdef DECIMAL_ADJ_EN
            if (busy) begin
                flag_c <= adj_carry;
            end
`endif
        end
    end

    assign c_out = flag_c;
    assign d_out = flag_d;
    assign p_out = {flag_n, flag_v, 1'b1, brk_flag, flag_d, flag_i, flag_z, flag_c};

endmodule

// File: tb/tb_alu_status_stage.sv
// Self-checking bench for alu_status_stage. Decimal tests are built when
// DECIMAL_ADJ_EN is defined; otherwise D is checked to leave results binary.
module tb_alu_status_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid;
    logic [7:0] alu_res;
    logic       alu_cout;
    logic       alu_ovf;
    logic [7:0] alu_ain;
    logic [7:0] alu_bin;
    logic       alu_inv;
    logic       alu_sum;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       set_c;
    logic       clr_c;
    logic       set_i;
    logic       clr_i;
    logic       set_d;
    logic       clr_d;
    logic       clr_v;
    logic       bit_op;
    logic       p_load;
    logic [7:0] p_din;
    logic       brk_flag;
    logic [7:0] add_out;
    logic       out_valid;
    logic       busy;
    logic       c_out;
    logic       d_out;
    logic [7:0] p_out;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] p;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_status_stage dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_res   (alu_res),
        .alu_cout  (alu_cout),
        .alu_ovf   (alu_ovf),
        .alu_ain   (alu_ain),
        .alu_bin   (alu_bin),
        .alu_inv   (alu_inv),
        .alu_sum   (alu_sum),
        .upd_nz    (upd_nz),
        .upd_c     (upd_c),
        .upd_v     (upd_v),
        .set_c     (set_c),
        .clr_c     (clr_c),
        .set_i     (set_i),
        .clr_i     (clr_i),
        .set_d     (set_d),
        .clr_d     (clr_d),
        .clr_v     (clr_v),
        .bit_op    (bit_op),
        .p_load    (p_load),
        .p_din     (p_din),
        .brk_flag  (brk_flag),
        .add_out   (add_out),
        .out_valid (out_valid),
        .busy      (busy),
        .c_out     (c_out),
        .d_out     (d_out),
        .p_out     (p_out)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task tick;
        @(posedge clk);
        #1;
    endtask

    task clear_inputs;
        alu_valid = 1'b0; alu_res = 8'h00; alu_cout = 1'b0; alu_ovf = 1'b0;
        alu_ain = 8'h00; alu_bin = 8'h00; alu_inv = 1'b0; alu_sum = 1'b0;
        upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0;
        set_c = 1'b0; clr_c = 1'b0; set_i = 1'b0; clr_i = 1'b0;
        set_d = 1'b0; clr_d = 1'b0; clr_v = 1'b0; bit_op = 1'b0;
        p_load = 1'b0; p_din = 8'h00;
    endtask

    // Present one ALU result with all three update qualifiers set.
    task drive_alu(input logic [7:0] ain, input logic [7:0] bin, input logic [7:0] res,
                   input logic cout, input logic ovf, input logic inv, input logic sum);
        alu_valid = 1'b1; alu_ain = ain; alu_bin = bin; alu_res = res;
        alu_cout = cout; alu_ovf = ovf; alu_inv = inv; alu_sum = sum;
        upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
    endtask

    task test_reset;
        exp_t e;
        clear_inputs();
        brk_flag = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (p_out !== 8'h24) begin errors++; $display("[TB] FAIL reset_p_out got=%h exp=24", p_out); end
        checks++; if (add_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_add_out got=%h exp=00", add_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({c_out, d_out} !== 2'b00) begin errors++; $display("[TB] FAIL reset_c_d got=%b%b exp=00", c_out, d_out); end
        brk_flag = 1'b1;
        #1;
        checks++; if (p_out !== 8'h34) begin errors++; $display("[TB] FAIL reset_brk got=%h exp=34", p_out); end
        brk_flag = 1'b0;
        e.res = 8'h00;
        e.p   = 8'h24;
        e = e;
    endtask

    task test_binary_capture;
        exp_t e;
        drive_alu(8'h09, 8'hFF, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1);
        e.res = 8'h08; e.p = 8'h25; sb.push_back(e);
        tick();
        clear_inputs();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bin_valid got=%b exp=1", out_valid); end
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("[TB] FAIL bin_sb got=empty exp=entry");
        end else begin
            e = sb.pop_front();
            if (add_out !== e.res || p_out !== e.p) begin
                errors++; $display("[TB] FAIL bin_result got=%h/%h exp=%h/%h", add_out, p_out, e.res, e.p);
            end
        end
        checks++; if (c_out !== 1'b1) begin errors++; $display("[TB] FAIL bin_c_out got=%b exp=1", c_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bin_pulse got=%b exp=0", out_valid); end
    endtask

    task test_back_to_back;
        exp_t e;
        logic [7:0] res_t [3];
        logic [7:0] exp_p [3];
        logic       cout_t [3];
        logic       ovf_t [3];
        logic       full_t [3];
        res_t = '{8'h80, 8'h00, 8'h80};
        cout_t = '{1'b0, 1'b1, 1'b0};
        ovf_t = '{1'b1, 1'b0, 1'b1};
        full_t = '{1'b1, 1'b1, 1'b0};
        exp_p = '{8'hE4, 8'h27, 8'hA5};
        for (int k = 0; k < 3; k++) begin
            drive_alu(8'h00, 8'h00, res_t[k], cout_t[k], ovf_t[k], 1'b0, 1'b1);
            upd_c = full_t[k];
            upd_v = full_t[k];
            e.res = res_t[k]; e.p = exp_p[k]; sb.push_back(e);
            tick();
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                errors++; $display("[TB] FAIL b2b_valid_%0d got=%b exp=1", k, out_valid);
            end else begin
                e = sb.pop_front();
                if (add_out !== e.res || p_out !== e.p) begin
                    errors++; $display("[TB] FAIL b2b_result_%0d got=%h/%h exp=%h/%h", k, add_out, p_out, e.res, e.p);
                end
            end
        end
        clear_inputs();
    endtask

    task test_flag_ops;
        exp_t e;
        clr_c = 1'b1; tick(); clear_inputs();
        checks++; if (p_out !== 8'hA4 || c_out !== 1'b0) begin errors++; $display("[TB] FAIL clr_c got=%h exp=a4", p_out); end
        set_c = 1'b1; clr_c = 1'b1; tick(); clear_inputs();
        checks++; if (p_out !== 8'hA5) begin errors++; $display("[TB] FAIL set_wins got=%h exp=a5", p_out); end
        set_d = 1'b1; clr_i = 1'b1; tick(); clear_inputs();
        checks++; if (p_out !== 8'hA9 || d_out !== 1'b1) begin errors++; $display("[TB] FAIL set_d_clr_i got=%h exp=a9", p_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flag_no_valid got=%b exp=0", out_valid); end
        set_i = 1'b1; clr_i = 1'b1; clr_d = 1'b1; tick(); clear_inputs();
        checks++; if (p_out !== 8'hA5) begin errors++; $display("[TB] FAIL set_i_clr_d got=%h exp=a5", p_out); end
        drive_alu(8'h00, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        set_c = 1'b1;
        e.res = 8'h80; e.p = 8'hE5; sb.push_back(e);
        tick(); clear_inputs();
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("[TB] FAIL cap_set_c_valid got=%b exp=1", out_valid);
        end else begin
            e = sb.pop_front();
            if (add_out !== e.res || p_out !== e.p) begin
                errors++; $display("[TB] FAIL cap_set_c got=%h/%h exp=%h/%h", add_out, p_out, e.res, e.p);
            end
        end
        clr_v = 1'b1; tick(); clear_inputs();
        checks++; if (p_out !== 8'hA5) begin errors++; $display("[TB] FAIL clr_v got=%h exp=a5", p_out); end
    endtask

    task test_p_load;
        p_load = 1'b1; p_din = 8'hFF;
        alu_valid = 1'b1; alu_res = 8'h00; alu_cout = 1'b1;
        upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
        tick(); clear_inputs();
        checks++; if (p_out !== 8'hEF) begin errors++; $display("[TB] FAIL pload_ff got=%h exp=ef", p_out); end
        checks++; if (out_valid !== 1'b0 || add_out !== 8'h80) begin errors++; $display("[TB] FAIL pload_ignores_cap got=%b/%h exp=0/80", out_valid, add_out); end
        brk_flag = 1'b1;
        #1;
        checks++; if (p_out !== 8'hFF) begin errors++; $display("[TB] FAIL pload_brk got=%h exp=ff", p_out); end
        brk_flag = 1'b0;
        p_load = 1'b1; p_din = 8'h30;
        tick(); clear_inputs();
        checks++; if (p_out !== 8'h20 || {c_out, d_out} !== 2'b00) begin errors++; $display("[TB] FAIL pload_30 got=%h exp=20", p_out); end
    endtask

    task test_bit_op;
        exp_t e;
        set_c = 1'b1; tick(); clear_inputs();
        alu_valid = 1'b1; bit_op = 1'b1; alu_bin = 8'hC0; alu_res = 8'h00; alu_cout = 1'b0;
        e.res = 8'h00; e.p = 8'hE3; sb.push_back(e);
        tick();
        alu_bin = 8'h00; alu_res = 8'h05;
        e.res = 8'h05; e.p = 8'h21; sb.push_back(e);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                errors++; $display("[TB] FAIL bit_valid_%0d got=%b exp=1", k, out_valid);
            end else begin
                e = sb.pop_front();
                if (add_out !== e.res || p_out !== e.p) begin
                    errors++; $display("[TB] FAIL bit_result_%0d got=%h/%h exp=%h/%h", k, add_out, p_out, e.res, e.p);
                end
            end
            if (k == 0) begin
                tick();
                clear_inputs();
            end
        end
    endtask

`ifdef DECIMAL_ADJ_EN
    task test_decimal;
        exp_t e;
        logic [7:0] ain_t [3];
        logic [7:0] bin_t [3];
        logic [7:0] res_t [3];
        logic       cout_t [3];
        logic       inv_t [3];
        logic [7:0] out_t [3];
        logic [7:0] p_t [3];
        ain_t = '{8'h09, 8'h99, 8'h10};
        bin_t = '{8'h01, 8'h01, 8'h01};
        res_t = '{8'h0A, 8'h9A, 8'h0F};
        cout_t = '{1'b0, 1'b0, 1'b1};
        inv_t = '{1'b0, 1'b0, 1'b1};
        out_t = '{8'h10, 8'h00, 8'h09};
        p_t = '{8'h28, 8'hA9, 8'h29};
        set_d = 1'b1; tick(); clear_inputs();
        checks++; if (p_out !== 8'h29) begin errors++; $display("[TB] FAIL dec_set_d got=%h exp=29", p_out); end
        for (int k = 0; k < 3; k++) begin
            drive_alu(ain_t[k], bin_t[k], res_t[k], cout_t[k], 1'b0, inv_t[k], 1'b1);
            e.res = out_t[k]; e.p = p_t[k]; sb.push_back(e);
            tick(); clear_inputs();
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dec_busy_%0d got=%b/%b exp=1/0", k, busy, out_valid); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || sb.size() == 0) begin
                errors++; $display("[TB] FAIL dec_valid_%0d got=%b/%b exp=1/0", k, out_valid, busy);
            end else begin
                e = sb.pop_front();
                if (add_out !== e.res || p_out !== e.p) begin
                    errors++; $display("[TB] FAIL dec_result_%0d got=%h/%h exp=%h/%h", k, add_out, p_out, e.res, e.p);
                end
            end
        end
        drive_alu(8'h09, 8'h01, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); clear_inputs();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL dec_rst_busy got=%b exp=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || add_out !== 8'h00 || p_out !== 8'h24) begin
            errors++; $display("[TB] FAIL dec_rst got=%b/%b/%h/%h exp=0/0/00/24", busy, out_valid, add_out, p_out);
        end
    endtask
`else
    task test_no_decimal;
        exp_t e;
        set_d = 1'b1; tick(); clear_inputs();
        checks++; if (p_out !== 8'h29 || d_out !== 1'b1) begin errors++; $display("[TB] FAIL nodec_set_d got=%h exp=29", p_out); end
        drive_alu(8'h09, 8'h01, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1);
        e.res = 8'h0A; e.p = 8'h28; sb.push_back(e);
        tick(); clear_inputs();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || sb.size() == 0) begin
            errors++; $display("[TB] FAIL nodec_valid got=%b/%b exp=1/0", out_valid, busy);
        end else begin
            e = sb.pop_front();
            if (add_out !== e.res || p_out !== e.p) begin
                errors++; $display("[TB] FAIL nodec_result got=%h/%h exp=%h/%h", add_out, p_out, e.res, e.p);
            end
        end
        drive_alu(8'h09, 8'h01, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick(); clear_inputs();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || add_out !== 8'h00 || p_out !== 8'h24) begin
            errors++; $display("[TB] FAIL nodec_rst got=%b/%h/%h exp=0/00/24", out_valid, add_out, p_out);
        end
    endtask
`endif

    initial begin
        $display("[TB] start");
        test_reset();
        test_binary_capture();
        test_back_to_back();
        test_flag_ops();
        test_p_load();
        test_bit_op();
`ifdef DECIMAL_ADJ_EN
        test_decimal();
`else
        test_no_decimal();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("[TB] FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
